// File: rtl/freq_synth_if.sv
// freq_synth_if: control and status bundle for the frequency synthesizer.
//   freq_in        requested frequency in Hz
//   freq_load      one-cycle strobe capturing freq_in as the pending value
//   enable         run request (level)
//   wave_out       synthesized 50 % duty square wave
//   edge_tick      one-cycle pulse aligned with the first high cycle of wave_out
//   running        synthesizer is in RUN or STOP
//   update_pending a loaded value has not yet been applied
//   freq_active    frequency currently being generated
// master drives the controls; slave is the synthesizer.
interface freq_synth_if #(
    parameter int unsigned FREQ_W = 14
) ();
    logic [FREQ_W-1:0] freq_in;
    logic              freq_load;
    logic              enable;
    logic              wave_out;
    logic              edge_tick;
    logic              running;
    logic              update_pending;
    logic [FREQ_W-1:0] freq_active;

    modport master (
        output freq_in, freq_load, enable,
        input  wave_out, edge_tick, running, update_pending, freq_active
    );

    modport slave (
        input  freq_in, freq_load, enable,
        output wave_out, edge_tick, running, update_pending, freq_active
    );
endinterface

// File: rtl/freq_synth.sv
// freq_synth: square-wave synthesizer built on a modulo-CLK_HZ accumulator (NCO).
// Every cycle in RUN/STOP the accumulator advances by 2*active; each wrap toggles
// wave_out, so exactly 2*active toggles happen per CLK_HZ cycles.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   bus    freq_synth_if.slave (controls in, wave and status out)
// Requires 2**ACC_W > CLK_HZ + 2*(2**FREQ_W - 1).
module freq_synth #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned FREQ_W = 14,
    parameter int unsigned ACC_W  = 27
) (
    input logic           clock,
    input logic           reset,
    freq_synth_if.slave   bus
);
    localparam logic [ACC_W-1:0] Modulus = ACC_W'(CLK_HZ);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e            state_q, state_d;
    logic [FREQ_W-1:0] pending_q, pending_d;
    logic [FREQ_W-1:0] active_q, active_d;
    logic              upd_q, upd_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              wave_q, wave_d;
    logic              tick_q, tick_d;
    logic              running_q, running_d;

    logic [ACC_W-1:0]  sum;
    logic              wrap;
    logic              apply;
    logic [FREQ_W-1:0] eff_freq;

    always_comb begin
        sum      = acc_q + {{(ACC_W-FREQ_W-1){1'b0}}, active_q, 1'b0};
        wrap     = (sum >= Modulus);
        eff_freq = upd_q ? pending_q : active_q;

        state_d = state_q;
        acc_d   = acc_q;
        wave_d  = wave_q;
        apply   = 1'b0;

        unique case (state_q)
            StIdle: begin
                acc_d  = '0;
                wave_d = 1'b0;
                apply  = upd_q;
                if (bus.enable && (eff_freq != '0)) begin
                    state_d = StRun;
                    wave_d  = 1'b1;
                end
            end
            StRun, StStop: begin
                if (!bus.enable && !wave_q) begin
                    // Low phase with no run request: nothing left to finish.
                    state_d = StIdle;
                    acc_d   = '0;
                end else begin
                    // STOP with enable back is just RUN; acc and wave untouched.
                    state_d = bus.enable ? StRun : StStop;
                    if (wrap) begin
                        acc_d  = sum - Modulus;
                        wave_d = ~wave_q;
                        if (wave_q) begin
                            // High->low toggle: period boundary, safe to stop or retune.
                            if (!bus.enable) begin
                                state_d = StIdle;
                                acc_d   = '0;
                            end else begin
                                apply = upd_q;
                                if (upd_q && (pending_q == '0)) begin
                                    state_d = StIdle;
                                    acc_d   = '0;
                                end
                            end
                        end
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                acc_d   = '0;
                wave_d  = 1'b0;
            end
        endcase

        // Apply consumes the old pending value; a same-cycle load stays pending.
        pending_d = bus.freq_load ? bus.freq_in : pending_q;
        upd_d     = bus.freq_load | (upd_q & ~apply);
        active_d  = apply ? pending_q : active_q;
        tick_d    = wave_d & ~wave_q;
        running_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= '0;
            active_q  <= '0;
            upd_q     <= 1'b0;
            acc_q     <= '0;
            wave_q    <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            upd_q     <= upd_d;
            acc_q     <= acc_d;
            wave_q    <= wave_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

    assign bus.wave_out       = wave_q;
    assign bus.edge_tick      = tick_q;
    assign bus.running        = running_q;
    assign bus.update_pending = upd_q;
    assign bus.freq_active    = active_q;
endmodule
